// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and load/store paths.
// Data wins ties unless fetch has lost STARVE_MAX contests in a row; each access holds mem_en_o for WAIT_CYCLES.
module mem_bus_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req_i,
    input  logic [AW-1:0] inst_addr_i,
    output logic [DW-1:0] inst_data_o,
    output logic          inst_ack_o,
    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_wdata_i,
    output logic [DW-1:0] data_rdata_o,
    output logic          data_ack_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD  = WCW'(WAIT_CYCLES - 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic [SCW-1:0] starve_cnt;
    logic           inst_elig;
    logic           data_elig;
    logic           grant_inst;
    logic           grant_data;

    // A requester is ineligible in its own ack cycle, so the other side can take that slot.
    always_comb begin
        inst_elig  = inst_req_i && !inst_ack_o;
        data_elig  = data_req_i && !data_ack_o;
        grant_inst = inst_elig && (!data_elig || (starve_cnt == STARVE_LIM));
        grant_data = data_elig && !grant_inst;
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            starve_cnt   <= '0;
            inst_data_o  <= '0;
            inst_ack_o   <= 1'b0;
            data_rdata_o <= '0;
            data_ack_o   <= 1'b0;
            mem_en_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            inst_ack_o <= 1'b0;
            data_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_inst) begin
                        state       <= BUSY_I;
                        wait_cnt    <= WAIT_LOAD;
                        starve_cnt  <= '0;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= inst_addr_i;
                        mem_wdata_o <= '0;
                    end else if (grant_data) begin
                        state       <= BUSY_D;
                        wait_cnt    <= WAIT_LOAD;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= data_we_i;
                        mem_addr_o  <= data_addr_i;
                        mem_wdata_o <= data_wdata_i;
                        if (inst_elig && (starve_cnt != STARVE_LIM))
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (wait_cnt == '0) begin
                        state       <= IDLE;
                        mem_en_o    <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        if (state == BUSY_I) begin
                            inst_ack_o  <= 1'b1;
                            inst_data_o <= mem_rdata_i;
                        end else begin
                            data_ack_o <= 1'b1;
                            // The registered write strobe doubles as the latched store flag.
                            if (!mem_we_o)
                                data_rdata_o <= mem_rdata_i;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
